// File: rtl/program_loader_pkg.sv
// Shared CPU package: pipeline constants plus boot-loader
// state encoding and defaults.
package program_loader_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int IMEM_WORDS_DEF = 256;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } ld_state_e;

  function automatic logic [XLEN-1:0] word_addr(
    input logic [15:0] idx
  );
    return {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs big-endian bytes into 32-bit words and keeps
// the running XOR of every byte shifted in.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last,
  output logic [7:0]  csum
);

  logic [23:0] sr;
  logic [1:0]  cnt;
  logic [7:0]  x;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
      x   <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
      x   <= '0;
    end else if (shift) begin
      sr  <= {sr[15:0], din};
      cnt <= cnt + 2'd1;
      x   <= x ^ din;
    end
  end

  // The fourth byte completes the word in the same cycle it arrives.
  assign last = shift && (cnt == 2'd3);
  assign word = {sr, din};
  assign csum = x;

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: parses a sync/count/payload/xor frame,
// writes instruction memory and releases the core reset.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAXW = 17'(IMEM_WORDS);

  ld_state_e   state;
  ld_state_e   state_n;
  logic [7:0]  cnt_hi;
  logic [15:0] count;
  logic [15:0] widx;
  logic [15:0] n_rx;
  logic        acc;
  logic        sync;
  logic        clear;
  logic        shift;
  logic        last;
  logic [31:0] word;
  logic [7:0]  csum;

  assign acc  = rx_valid & rx_ready;
  assign sync = (rx_data == SYNC_BYTE);
  assign n_rx = {cnt_hi, rx_data};

  word_assembler u_asm (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .shift (shift),
    .din   (rx_data),
    .word  (word),
    .last  (last),
    .csum  (csum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    clear   = 1'b0;
    shift   = 1'b0;
    if (acc) begin
      unique case (state)
        IDLE, ERROR: begin
          if (sync) begin
            state_n = CNT_HI;
            clear   = 1'b1;
          end
        end
        CNT_HI: state_n = CNT_LO;
        CNT_LO: begin
          if (n_rx == 16'd0)
            state_n = CHECK;
          else if ({1'b0, n_rx} > MAXW)
            state_n = ERROR;
          else
            state_n = DATA;
        end
        DATA: begin
          shift = 1'b1;
          if (last && (widx == count - 16'd1))
            state_n = CHECK;
        end
        CHECK: begin
          if (rx_data == csum) state_n = DONE;
          else                 state_n = ERROR;
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Status outputs follow the next state so they are glitch-free flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready   <= 1'b0;
      core_reset <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cnt_hi     <= '0;
      count      <= '0;
      widx       <= '0;
    end else begin
      rx_ready   <= (state_n != DONE);
      core_reset <= (state_n == DONE);
      done       <= (state_n == DONE);
      error      <= (state_n == ERROR);
      imem_we    <= last;
      if (last) begin
        imem_addr  <= word_addr(widx);
        imem_wdata <= word;
      end
      if (acc && state == CNT_HI) cnt_hi <= rx_data;
      if (acc && state == CNT_LO) count <= n_rx;
      if (clear)     widx <= '0;
      else if (last) widx <= widx + 16'd1;
    end
  end

endmodule
